// File: rtl/shift_add_controller_if.sv
// Handshake and strobe bundle between the shift-add controller, the system,
// the iteration counter and the multiplier datapath.
// master: controller side. slave: environment side (system, counter, datapath).
interface shift_add_controller_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             ready;
  logic             done;
  logic             q0;
  logic             cnt_end;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_up_down;
  logic [CNT_W-1:0] cnt_data;
  logic             ld_operands;
  logic             clr_acc;
  logic             acc_add;
  logic             shift_en;

  modport master (
    input  start, q0, cnt_end,
    output ready, done, cnt_load, cnt_en, cnt_up_down, cnt_data,
           ld_operands, clr_acc, acc_add, shift_en
  );

  modport slave (
    output start, q0, cnt_end,
    input  ready, done, cnt_load, cnt_en, cnt_up_down, cnt_data,
           ld_operands, clr_acc, acc_add, shift_en
  );
endinterface

// File: rtl/shift_add_controller.sv
// Control FSM for the shift-add multiplier. Loads the external down-counter
// with WIDTH, then runs WIDTH test/(add)/shift iterations until the counter
// reports zero, and pulses done for one cycle.
// Optional macro FUSED_ADD_SHIFT_EN: drops the ADD state and issues the
// conditional add together with the shift (acc_add = q0 during SHIFT).
//
// state | meaning
// IDLE  | ready, waiting for start
// LOAD  | load counter and operands, clear accumulator
// TEST  | counter at zero -> finish, else choose add or shift on q0
// ADD   | accumulate multiplicand (non-fused build only)
// SHIFT | shift {acc,multiplier} right, decrement counter
// DONE  | one-cycle done pulse, product valid
module shift_add_controller #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_add_controller_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
`ifndef FUSED_ADD_SHIFT_EN
    ADD   = 3'd3,
`endif
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Counter always counts down from the operand width.
  assign bus.cnt_up_down = 1'b0;
  assign bus.cnt_data    = CNT_W'(WIDTH);

  // State register; reset returns to IDLE at once, even mid-operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and Moore strobe decode.
  always_comb begin
    state_d         = state_q;
    bus.ready       = 1'b0;
    bus.done        = 1'b0;
    bus.cnt_load    = 1'b0;
    bus.cnt_en      = 1'b0;
    bus.ld_operands = 1'b0;
    bus.clr_acc     = 1'b0;
    bus.acc_add     = 1'b0;
    bus.shift_en    = 1'b0;
    case (state_q)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) state_d = LOAD;
      end
      LOAD: begin
        bus.cnt_load    = 1'b1;
        bus.ld_operands = 1'b1;
        bus.clr_acc     = 1'b1;
        state_d         = TEST;
      end
      TEST: begin
        // Counter output is registered, so this sees the post-load or
        // post-decrement value: exactly WIDTH passes before cnt_end.
        if (bus.cnt_end) state_d = DONE;
`ifdef FUSED_ADD_SHIFT_EN
        else             state_d = SHIFT;
`else
        else if (bus.q0) state_d = ADD;
        else             state_d = SHIFT;
`endif
      end
`ifndef FUSED_ADD_SHIFT_EN
      ADD: begin
        bus.acc_add = 1'b1;
        state_d     = SHIFT;
      end
`endif
      SHIFT: begin
`ifdef FUSED_ADD_SHIFT_EN
        // Datapath adds before shifting on the same edge.
        bus.acc_add = bus.q0;
`endif
        bus.shift_en = 1'b1;
        bus.cnt_en   = 1'b1;
        state_d      = TEST;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_add_controller.sv
// Bench for shift_add_controller: models the iteration counter and the
// multiplier datapath around the controller, and compares products,
// latency and strobe counts against arithmetic expectations.
module tb_shift_add_controller;
  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_add_controller_if #(.CNT_W(CW)) bus ();

  shift_add_controller #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Iteration counter: shares rst, clears to 0, registered output.
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (bus.cnt_load) cnt <= bus.cnt_data;
    else if (bus.cnt_en)   cnt <= bus.cnt_up_down ? cnt + 1'b1 : cnt - 1'b1;
  end
  assign bus.cnt_end = (cnt == '0);

  // Datapath: p = {carry, acc, multiplier}.
  logic [W-1:0]   op_a, op_b, mcand;
  logic [2*W:0]   p, p_next, p_add;
  always_comb begin
    p_add  = p;
    p_next = p;
    if (bus.acc_add) p_add[2*W:W] = {1'b0, p[2*W-1:W]} + {1'b0, mcand};
    p_next = bus.shift_en ? (p_add >> 1) : p_add;
  end
  always_ff @(posedge clk) begin
    if (bus.ld_operands) begin
      mcand <= op_a;
      p     <= {{(W+1){1'b0}}, op_b};
    end else begin
      p <= p_next;
    end
  end
  assign bus.q0 = p[0];

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: latency and product from the multiply rules alone.
  function automatic int ref_latency(input logic [W-1:0] b);
`ifdef FUSED_ADD_SHIFT_EN
    return 2*W + 3;
`else
    return 2*W + $countones(b) + 3;
`endif
  endfunction

  // One full operation from IDLE; counts cycles after the accepting edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [2*W-1:0] prod,
                        output int adds, output int shifts, output int ens,
                        output int viol);
    int n;
    bit seen;
    lat = 0; prod = '0; adds = 0; shifts = 0; ens = 0; viol = 0;
    op_a = a;
    op_b = b;
    n = 0;
    while (!bus.ready && n < 50) begin @(negedge clk); n++; end
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.acc_add)  adds++;
      if (bus.shift_en) shifts++;
      if (bus.cnt_en)   ens++;
      if (bus.cnt_load && bus.cnt_en) viol++;
`ifndef FUSED_ADD_SHIFT_EN
      if (bus.acc_add && bus.shift_en) viol++;
`endif
      if (bus.done) begin
        seen = 1'b1;
        prod = p[2*W-1:0];
      end
    end
    lat = n;
    if (!seen) check("done_timeout", 32'(n), 32'(0));
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
    int             lat_sep;
    int             lat_fused;
    int             adds;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, adds, shifts, ens, viol, n, loads;
    logic [2*W-1:0] prod;
    logic [W-1:0] ra, rb;
    bit seen;

    vecs[0] = '{8'h5A, 8'h00, 16'd0,     19, 19, 0};
    vecs[1] = '{8'h37, 8'hFF, 16'd14025, 27, 19, 8};
    vecs[2] = '{8'd13, 8'd11, 16'd143,   22, 19, 3};
    vecs[3] = '{8'hFF, 8'hFF, 16'd65025, 27, 19, 8};
    vecs[4] = '{8'h01, 8'h80, 16'd128,   20, 19, 1};
    vecs[5] = '{8'hFF, 8'h01, 16'd255,   20, 19, 1};

    // Reset held with start asserted: stays IDLE, all strobes quiet.
    rst = 1'b1;
    bus.start = 1'b1;
    op_a = '0;
    op_b = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_strobes", 32'({bus.cnt_load, bus.cnt_en, bus.ld_operands,
                              bus.clr_acc, bus.acc_add, bus.shift_en}), 32'd0);
    check("rst_up_down", 32'(bus.cnt_up_down), 32'd0);
    check("rst_cnt_data", 32'(bus.cnt_data), 32'(W));
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(bus.ready), 32'd1);
    check("idle_no_load", 32'(bus.cnt_load), 32'd0);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat, prod, adds, shifts, ens, viol);
      check($sformatf("tbl%0d_prod", i), 32'(prod), 32'(vecs[i].prod));
`ifdef FUSED_ADD_SHIFT_EN
      check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(vecs[i].lat_fused));
`else
      check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(vecs[i].lat_sep));
`endif
      check($sformatf("tbl%0d_adds", i), 32'(adds), 32'(vecs[i].adds));
      check($sformatf("tbl%0d_shifts", i), 32'(shifts), 32'(W));
      check($sformatf("tbl%0d_cnt_en", i), 32'(ens), 32'(W));
      check($sformatf("tbl%0d_excl", i), 32'(viol), 32'd0);
      @(negedge clk);
      check($sformatf("tbl%0d_back_idle", i), 32'(bus.ready), 32'd1);
    end

    // Randomized operands against the arithmetic reference.
    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, lat, prod, adds, shifts, ens, viol);
      check($sformatf("rnd%0d_prod", i), 32'(prod), 32'(ra) * 32'(rb));
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(ref_latency(rb)));
      check($sformatf("rnd%0d_adds", i), 32'(adds), 32'($countones(rb)));
      check($sformatf("rnd%0d_excl", i), 32'(viol), 32'd0);
    end

    // start raised during SHIFT and held through DONE is ignored mid-op.
    @(negedge clk);
    op_a = 8'd9;
    op_b = 8'h05;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0; loads = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.shift_en) bus.start = 1'b1;
      if (n >= 2 && bus.cnt_load) loads++;
      if (bus.done) seen = 1'b1;
    end
    check("midstart_lat", 32'(n), 32'(ref_latency(8'h05)));
    check("midstart_no_reload", 32'(loads), 32'd0);
    check("midstart_prod", 32'(p[2*W-1:0]), 32'd45);
    @(negedge clk);
    check("midstart_idle_ready", 32'(bus.ready), 32'd1);
    check("midstart_idle_no_load", 32'(bus.cnt_load), 32'd0);
    @(negedge clk);
    check("midstart_new_load", 32'(bus.cnt_load), 32'd1);
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 200) begin @(negedge clk); n++; end
    check("midstart_second_prod", 32'(p[2*W-1:0]), 32'd45);

    // Reset during an add: immediate IDLE, counter cleared, then full rerun.
    @(negedge clk);
    op_a = 8'd3;
    op_b = 8'h81;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0;
    while (!bus.acc_add && n < 50) begin @(negedge clk); n++; end
    check("midrst_reached_add", 32'(bus.acc_add), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_cnt_zero", 32'(cnt), 32'd0);
    check("midrst_no_add", 32'(bus.acc_add), 32'd0);
    @(negedge clk);
    check("midrst_hold_idle", 32'(bus.ready), 32'd1);
    rst = 1'b0;
    run_op(8'h9C, 8'h81, lat, prod, adds, shifts, ens, viol);
    check("midrst_rerun_prod", 32'(prod), 32'(8'h9C) * 32'(8'h81));
    check("midrst_rerun_lat", 32'(lat), 32'(ref_latency(8'h81)));
    check("midrst_rerun_shifts", 32'(shifts), 32'(W));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=expired required=finished");
    $fatal(1, "global timeout");
  end
endmodule
